// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Load-use stall, redirect squash and memory-wait freeze sequencer
//            for the 5-stage RISC-V pipeline. Optional performance counters
//            are enabled with the HAZARD_PERF_COUNTERS_EN macro.
// Revision : 1.0
// ============================================================================
module hazard_control_unit #(
    parameter int NBits        = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             ID_uses_rs1_i,
    input  logic             ID_uses_rs2_i,
    input  logic             EX_Mem_Read_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             EX_Redirect_i,
    input  logic             Mem_Req_i,
    input  logic             Mem_Ready_i,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             Bubble_Sel_o,
    output logic             Freeze_o
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [NBits-1:0] Stall_Count_o,
    output logic [NBits-1:0] Flush_Count_o
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam logic [2:0] RELOAD_CNT  = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    logic [1:0] state, next_state;
    logic [1:0] ret_state, next_ret_state;
    logic [1:0] eff_state;
    logic [2:0] cnt, next_cnt;
    logic       load_use;
    logic       mem_busy;

    assign load_use = EX_Mem_Read_i && (EX_rd_i != 5'd0) &&
                      ((ID_uses_rs1_i && (EX_rd_i == ID_rs1_i)) ||
                       (ID_uses_rs2_i && (EX_rd_i == ID_rs2_i)));
    assign mem_busy = Mem_Req_i && !Mem_Ready_i;

    // A memory wait behaves exactly like the state it interrupted once released.
    assign eff_state = (state == ST_MEM_WAIT) ? ret_state : state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            cnt       <= 3'd0;
        end else begin
            state     <= next_state;
            ret_state <= next_ret_state;
            cnt       <= next_cnt;
        end
    end

    always_comb begin
        next_state     = ST_RUN;
        next_ret_state = ST_RUN;
        next_cnt       = cnt;
        if (mem_busy) begin
            next_state     = ST_MEM_WAIT;
            next_ret_state = eff_state;
        end else if (EX_Redirect_i) begin
            if (MULTI_FLUSH) begin
                next_state = ST_REDIRECT;
                next_cnt   = RELOAD_CNT;
            end else begin
                next_cnt   = 3'd0;
            end
        end else if (eff_state == ST_REDIRECT) begin
            next_cnt = cnt - 3'd1;
            if (cnt > 3'd1) begin
                next_state = ST_REDIRECT;
            end
        end
    end

    always_comb begin
        PC_Write_o    = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_Flush_o = 1'b0;
        Bubble_Sel_o  = 1'b0;
        Freeze_o      = 1'b0;
        if (!reset) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            IF_ID_Flush_o = 1'b1;
            Bubble_Sel_o  = 1'b1;
        end else if (mem_busy) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            Freeze_o      = 1'b1;
        end else if (EX_Redirect_i || (eff_state == ST_REDIRECT)) begin
            IF_ID_Flush_o = 1'b1;
            Bubble_Sel_o  = 1'b1;
        end else if (load_use) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            Bubble_Sel_o  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [NBits-1:0] stall_count;
    logic [NBits-1:0] flush_count;
    logic             stall_event;

    // A bubble without a flush can only be a load-use stall.
    assign stall_event = Freeze_o || (Bubble_Sel_o && !IF_ID_Flush_o);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_event && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (IF_ID_Flush_o && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign Stall_Count_o = stall_count;
    assign Flush_Count_o = flush_count;
`endif

endmodule
`default_nettype wire
